// File: rtl/mips_pkg.sv
// Shared MIPS core definitions: multiply/divide op and state encodings plus
// the SPECIAL-opcode funct codes the decoder uses to route to the unit.
package mips_pkg;

  typedef enum logic [1:0] {
    MD_MULTU = 2'b00,
    MD_MULT  = 2'b01,
    MD_DIVU  = 2'b10,
    MD_DIV   = 2'b11
  } md_op_t;

  typedef enum logic [1:0] {
    MD_IDLE = 2'b00,
    MD_CALC = 2'b01,
    MD_FIX  = 2'b10,
    MD_DONE = 2'b11
  } md_state_t;

  localparam logic [5:0] FUNCT_MFHI  = 6'h10;
  localparam logic [5:0] FUNCT_MTHI  = 6'h11;
  localparam logic [5:0] FUNCT_MFLO  = 6'h12;
  localparam logic [5:0] FUNCT_MTLO  = 6'h13;
  localparam logic [5:0] FUNCT_MULT  = 6'h18;
  localparam logic [5:0] FUNCT_MULTU = 6'h19;
  localparam logic [5:0] FUNCT_DIV   = 6'h1A;
  localparam logic [5:0] FUNCT_DIVU  = 6'h1B;

  // Decoder helper: map a mult/div funct code onto the unit's op field.
  function automatic md_op_t funct_to_md_op(input logic [5:0] funct);
    md_op_t r;
    case (funct)
      FUNCT_MULT:  r = MD_MULT;
      FUNCT_MULTU: r = MD_MULTU;
      FUNCT_DIV:   r = MD_DIV;
      FUNCT_DIVU:  r = MD_DIVU;
      default:     r = MD_MULTU;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/iter_multdiv.sv
// Iterative multiply/divide: radix-2 shift-add multiply and restoring divide on
// operand magnitudes, one bit per cycle, with a sign fix-up cycle before done.
module iter_multdiv
  import mips_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cancel,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  function automatic logic [WIDTH-1:0] neg_w(input logic [WIDTH-1:0] v);
    return ~v + {{(WIDTH-1){1'b0}}, 1'b1};
  endfunction

  function automatic logic [2*WIDTH-1:0] neg_2w(input logic [2*WIDTH-1:0] v);
    return ~v + {{(2*WIDTH-1){1'b0}}, 1'b1};
  endfunction

  md_state_t          state_q, state_d;
  md_op_t             op_q, op_d;
  logic               neg_res_q, neg_res_d;
  logic               neg_rem_q, neg_rem_d;
  logic               div0_q, div0_d;
  logic [WIDTH-1:0]   a_raw_q, a_raw_d;
  logic [WIDTH-1:0]   opa_q, opa_d;
  logic [WIDTH-1:0]   opb_q, opb_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH:0]     rem_q, rem_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;

  logic               is_div_s;
  logic               start_signed_s;
  logic               neg_a_s;
  logic               neg_b_s;
  logic [WIDTH:0]     mul_sum_s;
  logic [WIDTH+1:0]   div_trial_s;
  logic [2*WIDTH-1:0] prod_s;

  // Next-state, datapath iteration and result fix-up
  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    div0_d    = div0_q;
    a_raw_d   = a_raw_q;
    opa_d     = opa_q;
    opb_d     = opb_q;
    acc_d     = acc_q;
    rem_d     = rem_q;
    cnt_d     = cnt_q;
    hi_d      = hi_q;
    lo_d      = lo_q;

    is_div_s       = (op_q == MD_DIVU) || (op_q == MD_DIV);
    start_signed_s = (op == MD_MULT) || (op == MD_DIV);
    neg_a_s        = start_signed_s & a[WIDTH-1];
    neg_b_s        = start_signed_s & b[WIDTH-1];

    // Shift-add keeps the multiplier in opb (LSB first) and the magnitude
    // product in acc; restoring divide shifts dividend bits out of opa's MSB
    // and the quotient bits back in at its LSB.
    mul_sum_s   = {1'b0, acc_q[2*WIDTH-1:WIDTH]}
                + (opb_q[0] ? {1'b0, opa_q} : {(WIDTH+1){1'b0}});
    div_trial_s = {rem_q, opa_q[WIDTH-1]} - {2'b00, opb_q};
    prod_s      = neg_res_q ? neg_2w(acc_q) : acc_q;

    if (cancel) begin
      state_d = MD_IDLE;
    end else begin
      case (state_q)
        MD_IDLE: begin
          if (start) begin
            state_d   = MD_CALC;
            op_d      = md_op_t'(op);
            neg_res_d = neg_a_s ^ neg_b_s;
            neg_rem_d = neg_a_s;
            div0_d    = (b == {WIDTH{1'b0}});
            a_raw_d   = a;
            opa_d     = neg_a_s ? neg_w(a) : a;
            opb_d     = neg_b_s ? neg_w(b) : b;
            acc_d     = {(2*WIDTH){1'b0}};
            rem_d     = {(WIDTH+1){1'b0}};
            cnt_d     = {CNT_W{1'b0}};
          end else begin
            state_d = MD_IDLE;
          end
        end
        MD_CALC: begin
          if (is_div_s) begin
            if (div_trial_s[WIDTH+1]) begin
              rem_d = {rem_q[WIDTH-1:0], opa_q[WIDTH-1]};
            end else begin
              rem_d = div_trial_s[WIDTH:0];
            end
            opa_d = {opa_q[WIDTH-2:0], ~div_trial_s[WIDTH+1]};
          end else begin
            acc_d = {mul_sum_s, acc_q[WIDTH-1:1]};
            opb_d = {1'b0, opb_q[WIDTH-1:1]};
          end
          cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
          if (cnt_q == CNT_LAST) begin
            state_d = MD_FIX;
          end else begin
            state_d = MD_CALC;
          end
        end
        MD_FIX: begin
          state_d = MD_DONE;
          if (!is_div_s) begin
            hi_d = prod_s[2*WIDTH-1:WIDTH];
            lo_d = prod_s[WIDTH-1:0];
          end else if (div0_q) begin
            hi_d = a_raw_q;
            lo_d = {WIDTH{1'b1}};
          end else begin
            hi_d = neg_rem_q ? neg_w(rem_q[WIDTH-1:0]) : rem_q[WIDTH-1:0];
            lo_d = neg_res_q ? neg_w(opa_q) : opa_q;
          end
        end
        MD_DONE: begin
          state_d = MD_IDLE;
        end
        default: begin
          state_d = MD_IDLE;
        end
      endcase
    end

    busy_d = (state_d != MD_IDLE);
    done_d = (state_d == MD_DONE);
  end

  // State, datapath and registered outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= MD_IDLE;
      op_q      <= MD_MULTU;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      div0_q    <= 1'b0;
      a_raw_q   <= {WIDTH{1'b0}};
      opa_q     <= {WIDTH{1'b0}};
      opb_q     <= {WIDTH{1'b0}};
      acc_q     <= {(2*WIDTH){1'b0}};
      rem_q     <= {(WIDTH+1){1'b0}};
      cnt_q     <= {CNT_W{1'b0}};
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      hi_q      <= {WIDTH{1'b0}};
      lo_q      <= {WIDTH{1'b0}};
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
      div0_q    <= div0_d;
      a_raw_q   <= a_raw_d;
      opa_q     <= opa_d;
      opb_q     <= opb_d;
      acc_q     <= acc_d;
      rem_q     <= rem_d;
      cnt_q     <= cnt_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_iter_multdiv.sv
// Randomised and directed bench for iter_multdiv against an arithmetic model
// of MIPS MULT/MULTU/DIV/DIVU including divide-by-zero and abort behaviour.
module tb_iter_multdiv;

  localparam int W   = 32;
  localparam int LAT = W + 1;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         start = 1'b0;
  logic         cancel = 1'b0;
  logic [1:0]   op = 2'b00;
  logic [W-1:0] a = 32'h0;
  logic [W-1:0] b = 32'h0;
  logic         busy, done;
  logic [W-1:0] hi, lo;

  int           n_checks = 0;
  int           n_fail = 0;
  logic [W-1:0] exp_hi = 32'h0;
  logic [W-1:0] exp_lo = 32'h0;

  always #5 clk = ~clk;

  iter_multdiv #(.WIDTH(W)) dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .op     (op),
    .a      (a),
    .b      (b),
    .cancel (cancel),
    .busy   (busy),
    .done   (done),
    .hi     (hi),
    .lo     (lo)
  );

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // {hi, lo} as the MIPS ISA defines it, plus the all-ones / raw-a rule for b=0.
  function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    logic [63:0] ux, uy;
    longint      sx, sy, p, q, r;
    ux = {32'h0, x};
    uy = {32'h0, y};
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    case (o)
      2'b00: return ux * uy;
      2'b01: begin
        p = sx * sy;
        return p;
      end
      2'b10: begin
        if (y == 32'h0) return {x, 32'hFFFFFFFF};
        return {x % y, x / y};
      end
      default: begin
        if (y == 32'h0) return {x, 32'hFFFFFFFF};
        q = sx / sy;
        r = sx % sy;
        return {r[31:0], q[31:0]};
      end
    endcase
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 6))
      0: return 32'h0;
      1: return 32'hFFFFFFFF;
      2: return 32'h80000000;
      3: return 32'h1;
      4: return 32'h7FFFFFFF;
      default: return $urandom;
    endcase
  endfunction

  // Issue one op; with noise, keep start high with junk operands while busy.
  task automatic run_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y, input bit noise);
    logic [63:0] ev;
    int          lat;
    ev = model(o, x, y);
    op = o; a = x; b = y; start = 1'b1;
    @(posedge clk); #1;
    start = noise;
    op = 2'($urandom); a = $urandom; b = $urandom;
    check_eq("busy_after_start", busy, 1);
    lat = 0;
    while (!done && lat < 100) begin
      @(posedge clk); #1;
      lat++;
      if (noise) begin
        op = 2'($urandom); a = $urandom; b = $urandom;
      end
    end
    start = 1'b0;
    check_eq("latency", lat, LAT);
    check_eq("busy_at_done", busy, 1);
    check_eq("hi", hi, ev[63:32]);
    check_eq("lo", lo, ev[31:0]);
    exp_hi = ev[63:32];
    exp_lo = ev[31:0];
    @(posedge clk); #1;
    check_eq("done_fall", done, 0);
    check_eq("busy_fall", busy, 0);
    @(posedge clk); #1;
    check_eq("idle_after_op", {busy, done, hi, lo}, {2'b00, exp_hi, exp_lo});
  endtask

  // Cancel after 'at' iteration edges; nothing may be written or signalled.
  task automatic run_cancel(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y, input int at);
    int pulses;
    op = o; a = x; b = y; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (at) begin
      @(posedge clk); #1;
    end
    cancel = 1'b1;
    @(posedge clk); #1;
    cancel = 1'b0;
    check_eq("cancel_busy", busy, 0);
    check_eq("cancel_done", done, 0);
    pulses = 0;
    repeat (LAT + 4) begin
      @(posedge clk); #1;
      if (done || busy) pulses++;
    end
    check_eq("cancel_no_done", pulses, 0);
    check_eq("cancel_hilo", {hi, lo}, {exp_hi, exp_lo});
  endtask

  initial begin
    int pulses;
    repeat (3) @(posedge clk);
    #1;
    check_eq("reset_state", {busy, done, hi, lo}, 66'h0);
    reset = 1'b1;
    @(posedge clk); #1;

    run_op(2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0);
    run_op(2'b01, 32'hFFFFFFFD, 32'h00000005, 1'b0);
    run_op(2'b11, 32'hFFFFFFF9, 32'h00000002, 1'b0);
    run_op(2'b10, 32'h00000007, 32'h00000002, 1'b0);
    run_op(2'b11, 32'h80000000, 32'hFFFFFFFF, 1'b0);
    run_op(2'b10, 32'h00000005, 32'h00000000, 1'b0);
    run_op(2'b11, 32'hFFFFFFFB, 32'h00000000, 1'b0);
    run_op(2'b01, 32'h80000000, 32'h80000000, 1'b0);
    run_op(2'b11, 32'h00000007, 32'hFFFFFFFE, 1'b0);

    // Leaves hi/lo = 0x1234/0x5678 while start is hammered during busy.
    run_op(2'b10, 32'h0ACF1234, 32'h00002000, 1'b1);
    check_eq("prior_hi", hi, 32'h1234);
    check_eq("prior_lo", lo, 32'h5678);

    run_cancel(2'b01, $urandom, $urandom, 10);

    start = 1'b1; cancel = 1'b1; op = 2'b00; a = 32'h3; b = 32'h3;
    @(posedge clk); #1;
    start = 1'b0; cancel = 1'b0;
    check_eq("start_cancel_idle", {busy, done, hi, lo}, {2'b00, exp_hi, exp_lo});

    for (int i = 0; i < 4; i++) begin
      run_cancel(2'($urandom), $urandom, $urandom, $urandom_range(0, W));
    end

    op = 2'b11; a = 32'hFFFF0000; b = 32'h00000013; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    check_eq("reset_mid_calc", {busy, done, hi, lo}, 66'h0);
    exp_hi = 32'h0;
    exp_lo = 32'h0;
    @(posedge clk); #1;
    reset = 1'b1;
    pulses = 0;
    repeat (LAT + 4) begin
      @(posedge clk); #1;
      if (done || busy) pulses++;
    end
    check_eq("reset_no_done", pulses, 0);

    for (int i = 0; i < 30; i++) begin
      run_op(2'($urandom), pick(), pick(), 1'($urandom));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
